// File: rtl/ascii_angle_scaler_if.sv
// Parser-side bundle for the ASCII angle scaler: frame strobe and digit bytes in,
// status and servo targets out.
interface ascii_angle_scaler_if;
  logic       start;
  logic [7:0] az_h;
  logic [7:0] az_t;
  logic [7:0] az_u;
  logic [7:0] el_t;
  logic [7:0] el_u;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] servo_pos_az;
  logic [7:0] servo_pos_el;

  modport master (
    output start, az_h, az_t, az_u, el_t, el_u,
    input  busy, done, err, servo_pos_az, servo_pos_el
  );

  modport slave (
    input  start, az_h, az_t, az_u, el_t, el_u,
    output busy, done, err, servo_pos_az, servo_pos_el
  );
endinterface

// File: rtl/ascii_angle_scaler.sv
// Validates ASCII azimuth/elevation digits and scales them to 8-bit servo targets
// using one shared 18-cycle restoring divider; targets hold until a good frame lands.
module ascii_angle_scaler #(
  parameter int         AZ_FULL_SCALE = 270,
  parameter int         EL_FULL_SCALE = 180,
  parameter int         OUT_MAX       = 255,
  parameter logic [7:0] RESET_POS_AZ  = 8'd0,
  parameter logic [7:0] RESET_POS_EL  = 8'd0
) (
  input logic                  clk,
  input logic                  rst_n,
  ascii_angle_scaler_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, CHECK, CONV, DIV_AZ, DIV_EL, DONE} state_t;

  state_t      r_state;
  logic [7:0]  r_azH, r_azT, r_azU, r_elT, r_elU;
  logic        r_bad;
  logic        r_azClamp, r_elClamp;
  logic [17:0] r_quo;
  logic [16:0] r_rem;
  logic [4:0]  r_cnt;
  logic [7:0]  r_resAz;
  logic        r_busy, r_done, r_err;
  logic [7:0]  r_posAz, r_posEl;

  logic [9:0]  w_azBin;
  logic [6:0]  w_elBin;
  logic [17:0] w_azNum, w_elNum;
  logic [17:0] w_divisor, w_trial, w_remNext, w_quoNext;
  logic        w_fits, w_allDigits;

  function automatic logic isDigit(input logic [7:0] b);
    return (b >= 8'h30) && (b <= 8'h39);
  endfunction

  // Captured bytes are already range-checked by the time these are used, so the low nibble is the digit.
  assign w_azBin = 10'(r_azH[3:0]) * 10'd100 + 10'(r_azT[3:0]) * 10'd10 + 10'(r_azU[3:0]);
  assign w_elBin = 7'(r_elT[3:0]) * 7'd10 + 7'(r_elU[3:0]);
  assign w_azNum = 18'(w_azBin) * 18'(OUT_MAX);
  assign w_elNum = 18'(w_elBin) * 18'(OUT_MAX);

  assign w_allDigits = isDigit(r_azH) && isDigit(r_azT) && isDigit(r_azU) &&
                       isDigit(r_elT) && isDigit(r_elU);

  assign w_divisor = (r_state == DIV_EL) ? 18'(EL_FULL_SCALE) : 18'(AZ_FULL_SCALE);
  assign w_trial   = {r_rem, r_quo[17]};
  assign w_fits    = (w_trial >= w_divisor);
  assign w_remNext = w_fits ? (w_trial - w_divisor) : w_trial;
  assign w_quoNext = {r_quo[16:0], w_fits};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_azH     <= '0;
      r_azT     <= '0;
      r_azU     <= '0;
      r_elT     <= '0;
      r_elU     <= '0;
      r_bad     <= 1'b0;
      r_azClamp <= 1'b0;
      r_elClamp <= 1'b0;
      r_quo     <= '0;
      r_rem     <= '0;
      r_cnt     <= '0;
      r_resAz   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_posAz   <= RESET_POS_AZ;
      r_posEl   <= RESET_POS_EL;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (bus.start) begin
            r_azH   <= bus.az_h;
            r_azT   <= bus.az_t;
            r_azU   <= bus.az_u;
            r_elT   <= bus.el_t;
            r_elU   <= bus.el_u;
            r_busy  <= 1'b1;
            r_state <= CHECK;
          end else begin
            r_state <= IDLE;
          end
        end
        CHECK: begin
          r_bad   <= !w_allDigits;
          r_state <= CONV;
        end
        // A rejected frame exits here so that err lands two edges after start.
        CONV: begin
          if (r_bad) begin
            r_done  <= 1'b1;
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= DONE;
          end else begin
            r_azClamp <= (18'(w_azBin) >= 18'(AZ_FULL_SCALE));
            r_elClamp <= (18'(w_elBin) >= 18'(EL_FULL_SCALE));
            r_quo     <= w_azNum;
            r_rem     <= '0;
            r_cnt     <= '0;
            r_state   <= DIV_AZ;
          end
        end
        DIV_AZ: begin
          r_quo <= w_quoNext;
          r_rem <= w_remNext[16:0];
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd17) begin
            r_resAz <= r_azClamp ? 8'(OUT_MAX) : w_quoNext[7:0];
            r_quo   <= w_elNum;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_state <= DIV_EL;
          end
        end
        // The final elevation bit is taken straight from the divider so both targets update together.
        DIV_EL: begin
          r_quo <= w_quoNext;
          r_rem <= w_remNext[16:0];
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd17) begin
            r_posAz <= r_resAz;
            r_posEl <= r_elClamp ? 8'(OUT_MAX) : w_quoNext[7:0];
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.err          = r_err;
  assign bus.servo_pos_az = r_posAz;
  assign bus.servo_pos_el = r_posEl;

endmodule

// File: tb/tb_ascii_angle_scaler.sv
// Directed plus randomized checks of ascii_angle_scaler against an arithmetic model
// of digit validation, scaling, clamping and fixed latency.
module tb_ascii_angle_scaler;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  int   expAz = 0;
  int   expEl = 0;
  int   lat;

  ascii_angle_scaler_if bus ();

  ascii_angle_scaler dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #10 clk = ~clk;

  function automatic bit digitOk(input logic [7:0] b);
    return (b >= "0") && (b <= "9");
  endfunction

  function automatic int scaleTo(input int bin, input int full);
    if (bin >= full) return 255;
    return (bin * 255) / full;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Drives digits with start; returns #1 after the edge that samples start (edge E).
  task automatic applyStimulus(input logic [7:0] h, t, u, et, eu, input bit atNegedge);
    if (atNegedge) @(negedge clk);
    bus.az_h = h; bus.az_t = t; bus.az_u = u; bus.el_t = et; bus.el_u = eu;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic waitDone(input int already, output int latency);
    latency = 0;
    for (int k = already + 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        latency = k;
        break;
      end
    end
  endtask

  task automatic updateModel(input logic [7:0] h, t, u, et, eu, output bit valid);
    valid = digitOk(h) && digitOk(t) && digitOk(u) && digitOk(et) && digitOk(eu);
    if (valid) begin
      expAz = scaleTo((int'(h) - 48) * 100 + (int'(t) - 48) * 10 + (int'(u) - 48), 270);
      expEl = scaleTo((int'(et) - 48) * 10 + (int'(eu) - 48), 180);
    end
  endtask

  task automatic checkResult(input string tag, input bit valid, input int latency);
    checkOutput({tag, ".latency"}, latency, valid ? 38 : 2);
    checkOutput({tag, ".err"}, bus.err, valid ? 0 : 1);
    checkOutput({tag, ".busy"}, bus.busy, 0);
    checkOutput({tag, ".az"}, bus.servo_pos_az, expAz);
    checkOutput({tag, ".el"}, bus.servo_pos_el, expEl);
  endtask

  task automatic runFrame(input string tag, input logic [7:0] h, t, u, et, eu);
    bit valid;
    applyStimulus(h, t, u, et, eu, 1'b1);
    checkOutput({tag, ".busyE"}, bus.busy, 1);
    waitDone(0, lat);
    updateModel(h, t, u, et, eu, valid);
    checkResult(tag, valid, lat);
  endtask

  initial begin
    bit valid;
    logic [7:0] d [5];
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.az_h = "0"; bus.az_t = "0"; bus.az_u = "0"; bus.el_t = "0"; bus.el_u = "0";
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset.busy", bus.busy, 0);
    checkOutput("reset.done", bus.done, 0);
    checkOutput("reset.err", bus.err, 0);
    checkOutput("reset.az", bus.servo_pos_az, 0);
    checkOutput("reset.el", bus.servo_pos_el, 0);
    @(negedge clk);
    rst_n = 1'b1;

    runFrame("f135_45", "1", "3", "5", "4", "5");
    runFrame("f269_00", "2", "6", "9", "0", "0");
    runFrame("f270_99", "2", "7", "0", "9", "9");
    runFrame("f999_99", "9", "9", "9", "9", "9");
    runFrame("f135_45b", "1", "3", "5", "4", "5");
    runFrame("bad1A5", "1", "A", "5", "4", "5");

    // start held high then re-pulsed at E+10 must not disturb the conversion
    applyStimulus("0", "9", "0", "3", "6", 1'b1);
    bus.start = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    waitDone(10, lat);
    updateModel("0", "9", "0", "3", "6", valid);
    checkResult("holdStart", valid, lat);

    // start in the done cycle is accepted as a new frame
    applyStimulus("1", "8", "0", "9", "0", 1'b0);
    checkOutput("doneStart.busyE", bus.busy, 1);
    waitDone(0, lat);
    updateModel("1", "8", "0", "9", "0", valid);
    checkResult("doneStart", valid, lat);
    @(posedge clk);
    #1;
    checkOutput("doneStart.pulse", bus.done, 0);

    // digits change right after capture; result must reflect captured bytes
    applyStimulus("2", "0", "0", "1", "5", 1'b1);
    bus.az_h = "8"; bus.az_t = "8"; bus.az_u = "8"; bus.el_t = "1"; bus.el_u = "2";
    waitDone(0, lat);
    updateModel("2", "0", "0", "1", "5", valid);
    checkResult("captured", valid, lat);

    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < 5; i++)
        d[i] = ($urandom_range(0, 11) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(48, 57));
      runFrame($sformatf("rand%0d", n), d[0], d[1], d[2], d[3], d[4]);
    end

    runFrame("preReset", "1", "3", "5", "4", "5");
    applyStimulus("2", "0", "0", "5", "0", 1'b1);
    repeat (19) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    expAz = 0;
    expEl = 0;
    checkOutput("midReset.az", bus.servo_pos_az, expAz);
    checkOutput("midReset.el", bus.servo_pos_el, expEl);
    checkOutput("midReset.busy", bus.busy, 0);
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      #1;
      if (k == 3) rst_n = 1'b1;
      if (bus.done) checkOutput("midReset.noDone", bus.done, 0);
    end
    checkOutput("midReset.idleBusy", bus.busy, 0);
    runFrame("postReset", "0", "4", "5", "1", "8");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ascii_angle_scaler.md
# ascii_angle_scaler

Sequential ASCII-to-servo-target converter that sits between the Bluetooth frame parser and the two smoothed servo PWM controllers. On each parsed frame it validates the ASCII azimuth/elevation digits, converts them to binary and scales them to 8-bit servo targets with a shared iterative restoring divider, removing the wide combinational multiply/divide from the top level. Outputs hold the last good targets until a new valid frame completes.

## Interface
- AZ_FULL_SCALE, 270, azimuth input value mapped to OUT_MAX; inputs ≥ this clamp to OUT_MAX
- EL_FULL_SCALE, 180, elevation input value mapped to OUT_MAX; inputs ≥ this clamp to OUT_MAX
- OUT_MAX, 255, full-scale servo target (must fit 8 bits)
- RESET_POS_AZ, 0, servo_pos_az value after reset
- RESET_POS_EL, 0, servo_pos_el value after reset

- clk  in  1  system clock, 50 MHz; one clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  frame-complete strobe from parser; sampled only when busy=0
- az_h, az_t, az_u  in  8 each  azimuth ASCII digits (hundreds, tens, units)
- el_t, el_u  in  8 each  elevation ASCII digits (tens, units)
- busy  out  1  conversion in progress
- done  out  1  one-cycle completion pulse
- err  out  1  valid only with done; 1 = frame rejected
- servo_pos_az  out  8  azimuth servo target
- servo_pos_el  out  8  elevation servo target

## Operation
- States: IDLE, CHECK, CONV, DIV_AZ, DIV_EL, DONE.
- IDLE: on start=1 capture all five digit bytes into internal registers (inputs may change afterwards); go CHECK.
- CHECK: every captured byte must be 0x30–0x39. Any failure → DONE with err=1; servo outputs unchanged.
- CONV: az_bin = 100·h + 10·t + u (10 bits, 0–999); el_bin = 10·t + u (7 bits, 0–99). Set clamp flags az_bin ≥ AZ_FULL_SCALE, el_bin ≥ EL_FULL_SCALE. Numerator = bin·OUT_MAX, 18 bits, unsigned.
- DIV_AZ / DIV_EL: restoring division of numerator by the full-scale parameter, one quotient bit per cycle, exactly 18 cycles each, MSB first; quotient = floor(numerator / FULL_SCALE). Clamped operands still run all 18 cycles; result then forced to OUT_MAX.
- DONE: load both results into servo_pos_az/servo_pos_el simultaneously (no half-updated pair ever visible), pulse done, err=0; return to IDLE.
- err frames: done=1, err=1, servo outputs keep prior values.
- start while busy=1: ignored, no queuing.
- Divider shared between axes via a single 18-bit remainder/quotient datapath.

## Timing
- Reset (async assert): state IDLE, busy=0, done=0, err=0, servo_pos_az=RESET_POS_AZ, servo_pos_el=RESET_POS_EL. Reset mid-conversion aborts; no done pulse.
- start sampled at edge E: busy=1 from E to E+38.
- Valid frame: outputs update and done rises at edge E+38; done high exactly one cycle; busy=0 in that cycle.
- Invalid frame: done=1, err=1 rise at edge E+2 for one cycle; busy=1 only from E to E+1.
- start=1 during the done cycle is accepted (busy=0), becoming the next edge E.
- Fixed latency regardless of clamp or digit values.

## Test plan
- Digits "135"/"45", start pulse → done at E+38, err=0, servo_pos_az=127, servo_pos_el=63.
- Digits "269"/"00" → servo_pos_az=254, servo_pos_el=0; then "270"/"99" → 255/140; then "999"/"99" → 255/140 (clamp, same latency).
- Digits "1A5"/"45" after a good frame → done+err at E+2, outputs unchanged from previous frame.
- start held high / re-pulsed at E+10 → ignored, single done at E+38; start pulsed in done cycle → second done 38 edges later.
- Digit inputs changed at E+1 → results reflect values captured at E.
- rst_n low at E+20 → outputs to RESET_POS_AZ/RESET_POS_EL immediately, no done; fresh start after release converts normally.
